// File: rtl/game_pkg.sv
//------------------------------------------------------------------------------
// game_pkg : shared screen geometry, coordinate type and ship FSM encoding
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package game_pkg;

    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int SCREEN_CORDW = 16;

    typedef logic [SCREEN_CORDW-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CALC       = 2'd2,
        COMMIT     = 2'd3
    } ship_state_t;

endpackage

`default_nettype wire

// File: rtl/fire_debounce.sv
//------------------------------------------------------------------------------
// fire_debounce : button synchroniser, frame-sampled debounce, rise detect
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fire_debounce #(
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic clk_pix,
    input  logic rst_n,
    input  logic sample_en,
    input  logic btn_raw,
    output logic pressed,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] count;
    logic             differs;
    logic             toggle;

    assign differs = (sync[1] != pressed);
    assign toggle  = sample_en && differs && (count == CNT_W'(DEBOUNCE_FRAMES - 1));
    // Combinational so the launch can be decided in the same sampling cycle
    assign rise    = toggle && !pressed;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= 2'b00;
            count   <= '0;
            pressed <= 1'b0;
        end else begin
            sync <= {sync[0], btn_raw};
            if (sample_en) begin
                if (!differs) begin
                    count <= '0;
                end else if (toggle) begin
                    count   <= '0;
                    pressed <= !pressed;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ship_motion_ctrl.sv
//------------------------------------------------------------------------------
// ship_motion_ctrl : frame-synchronous ship position and shot launch control
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ship_motion_ctrl
    import game_pkg::*;
#(
    parameter int SHIP_W_PX       = 68,
    parameter int SHIP_Y          = 300,
    parameter int START_X         = 286,
    parameter int DEADZONE        = 16,
    parameter int SPEED_SHIFT     = 5,
    parameter int MAX_STEP        = 8,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic                    clk_pix,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    frame,
    input  logic signed [9:0]       tilt,
    input  logic                    tilt_valid,
    input  logic                    fire_btn,
    output logic [SCREEN_CORDW-1:0] ship_x,
    output logic [SCREEN_CORDW-1:0] ship_y,
    output logic                    shot_req,
    output logic [SCREEN_CORDW-1:0] shot_x,
    output logic [SCREEN_CORDW-1:0] shot_y,
    output logic                    cooldown_active
);

    localparam int X_MAX  = H_RES - SHIP_W_PX;
    localparam int STEP_W = $clog2(MAX_STEP + 1);
    localparam int CD_W   = $clog2(COOLDOWN_FRAMES + 1);

    ship_state_t              state, state_next;
    logic signed [9:0]        tilt_reg;
    logic signed [9:0]        tilt_snap;
    logic [STEP_W-1:0]        step_reg, step_calc;
    logic                     step_neg;
    logic [CD_W-1:0]          cooldown, cooldown_next;
    logic [9:0]               mag, excess, scaled;
    logic signed [SCREEN_CORDW:0] x_sum, step_s;
    coord_t                   x_new;
    logic                     commit_en, launch;
    logic                     fire_pressed, fire_rise;

    assign ship_y    = SCREEN_CORDW'(SHIP_Y);
    assign commit_en = (state == COMMIT) && enable;
    assign launch    = commit_en && fire_rise && !fire_pressed && (cooldown == '0);

    fire_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_fire_debounce (
        .clk_pix   (clk_pix),
        .rst_n     (rst_n),
        .sample_en (commit_en),
        .btn_raw   (fire_btn),
        .pressed   (fire_pressed),
        .rise      (fire_rise)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (enable) state_next = WAIT_FRAME;
            WAIT_FRAME: begin
                if (!enable)    state_next = IDLE;
                else if (frame) state_next = CALC;
            end
            CALC:       state_next = COMMIT;
            COMMIT:     state_next = enable ? WAIT_FRAME : IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Magnitude of -512 is 512, which still fits the unsigned 10-bit range
    always_comb begin
        mag       = tilt_snap[9] ? $unsigned(-tilt_snap) : $unsigned(tilt_snap);
        excess    = '0;
        scaled    = '0;
        step_calc = '0;
        if (mag > 10'(DEADZONE)) begin
            excess = mag - 10'(DEADZONE);
            scaled = excess >> SPEED_SHIFT;
            if (scaled == '0)
                step_calc = STEP_W'(1);
            else if (scaled > 10'(MAX_STEP))
                step_calc = STEP_W'(MAX_STEP);
            else
                step_calc = scaled[STEP_W-1:0];
        end
    end

    always_comb begin
        step_s = $signed((SCREEN_CORDW + 1)'(step_reg));
        x_sum  = step_neg ? ($signed({1'b0, ship_x}) - step_s)
                          : ($signed({1'b0, ship_x}) + step_s);
        if (x_sum[SCREEN_CORDW])
            x_new = '0;
        else if (x_sum > $signed((SCREEN_CORDW + 1)'(X_MAX)))
            x_new = SCREEN_CORDW'(X_MAX);
        else
            x_new = x_sum[SCREEN_CORDW-1:0];
    end

    always_comb begin
        cooldown_next = cooldown;
        if (launch)
            cooldown_next = CD_W'(COOLDOWN_FRAMES);
        else if (commit_en && (cooldown != '0))
            cooldown_next = cooldown - CD_W'(1);
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            tilt_reg        <= '0;
            tilt_snap       <= '0;
            step_reg        <= '0;
            step_neg        <= 1'b0;
            ship_x          <= SCREEN_CORDW'(START_X);
            cooldown        <= '0;
            cooldown_active <= 1'b0;
            shot_req        <= 1'b0;
            shot_x          <= '0;
            shot_y          <= '0;
        end else begin
            if (tilt_valid)
                tilt_reg <= tilt;
            // Snapshot at the frame edge so a coincident tilt_valid lands next frame
            if ((state == WAIT_FRAME) && (state_next == CALC))
                tilt_snap <= tilt_reg;
            if (state == CALC) begin
                step_reg <= step_calc;
                step_neg <= tilt_snap[9];
            end
            if (commit_en)
                ship_x <= x_new;
            cooldown        <= cooldown_next;
            cooldown_active <= (cooldown_next != '0);
            shot_req        <= launch;
            if (launch) begin
                shot_x <= x_new + SCREEN_CORDW'(SHIP_W_PX / 2);
                shot_y <= SCREEN_CORDW'(SHIP_Y - 1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ship_motion_ctrl.sv
//------------------------------------------------------------------------------
// tb_ship_motion_ctrl : table-driven frame vectors plus reset/timing sequences
// Revision            : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ship_motion_ctrl;

    logic               clk_pix = 1'b0;
    logic               rst_n;
    logic               enable;
    logic               frame;
    logic signed [9:0]  tilt;
    logic               tilt_valid;
    logic               fire_btn;
    logic [15:0]        ship_x, ship_y, shot_x, shot_y;
    logic               shot_req;
    logic               cooldown_active;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic signed [9:0] tilt;
        logic              fire;
        int                exp_x;
        logic              exp_shot;
        logic              exp_cd;
    } vec_t;

    vec_t vecs[$];

    ship_motion_ctrl dut (
        .clk_pix         (clk_pix),
        .rst_n           (rst_n),
        .enable          (enable),
        .frame           (frame),
        .tilt            (tilt),
        .tilt_valid      (tilt_valid),
        .fire_btn        (fire_btn),
        .ship_x          (ship_x),
        .ship_y          (ship_y),
        .shot_req        (shot_req),
        .shot_x          (shot_x),
        .shot_y          (shot_y),
        .cooldown_active (cooldown_active)
    );

    always #20 clk_pix = ~clk_pix;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void add(input int t, input logic f, input int x,
                                input logic s, input logic c);
        vec_t v;
        v.tilt     = 10'(t);
        v.fire     = f;
        v.exp_x    = x;
        v.exp_shot = s;
        v.exp_cd   = c;
        vecs.push_back(v);
    endfunction

    // Loads tilt and fire level, then one frame pulse; checks the 2-cycle commit latency
    task automatic run_frame(input vec_t v, input int idx, input int prev_x);
        @(negedge clk_pix);
        tilt       = v.tilt;
        tilt_valid = 1'b1;
        fire_btn   = v.fire;
        @(negedge clk_pix);
        tilt_valid = 1'b0;
        repeat (3) @(negedge clk_pix);
        frame = 1'b1;
        @(negedge clk_pix);
        frame = 1'b0;
        @(posedge clk_pix); #1;
        check($sformatf("v%0d_x_early", idx), 32'(ship_x), 32'(prev_x));
        @(posedge clk_pix); #1;
        check($sformatf("v%0d_x", idx), 32'(ship_x), 32'(v.exp_x));
        check($sformatf("v%0d_shot_req", idx), 32'(shot_req), 32'(v.exp_shot));
        check($sformatf("v%0d_cooldown", idx), 32'(cooldown_active), 32'(v.exp_cd));
        if (v.exp_shot) begin
            check($sformatf("v%0d_shot_x", idx), 32'(shot_x), 32'(v.exp_x + 34));
            check($sformatf("v%0d_shot_y", idx), 32'(shot_y), 32'd299);
        end
        @(posedge clk_pix); #1;
        check($sformatf("v%0d_shot_pulse_end", idx), 32'(shot_req), 32'd0);
    endtask

    task automatic pulse_frame(input int cycles_high);
        @(negedge clk_pix);
        frame = 1'b1;
        repeat (cycles_high) @(negedge clk_pix);
        frame = 1'b0;
        repeat (5) @(negedge clk_pix);
    endtask

    initial begin
        int prev;

        rst_n      = 1'b0;
        enable     = 1'b0;
        frame      = 1'b0;
        tilt       = '0;
        tilt_valid = 1'b0;
        fire_btn   = 1'b0;

        for (int i = 0; i < 5; i++) add(0, 1'b0, 286, 1'b0, 1'b0);
        add(200, 1'b0, 291, 1'b0, 1'b0);
        add(200, 1'b0, 296, 1'b0, 1'b0);
        add(200, 1'b0, 301, 1'b0, 1'b0);
        add(10, 1'b0, 301, 1'b0, 1'b0);
        add(10, 1'b0, 301, 1'b0, 1'b0);
        add(20, 1'b0, 302, 1'b0, 1'b0);
        add(20, 1'b0, 303, 1'b0, 1'b0);
        for (int k = 1; k <= 37; k++) add(-511, 1'b0, 303 - 8 * k, 1'b0, 1'b0);
        add(-20, 1'b0, 6, 1'b0, 1'b0);
        add(-20, 1'b0, 5, 1'b0, 1'b0);
        add(-20, 1'b0, 4, 1'b0, 1'b0);
        add(-511, 1'b0, 0, 1'b0, 1'b0);
        add(-511, 1'b0, 0, 1'b0, 1'b0);
        add(-512, 1'b0, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 71; k++) add(511, 1'b0, 8 * k, 1'b0, 1'b0);
        add(20, 1'b0, 569, 1'b0, 1'b0);
        add(20, 1'b0, 570, 1'b0, 1'b0);
        add(511, 1'b0, 572, 1'b0, 1'b0);
        add(511, 1'b0, 572, 1'b0, 1'b0);
        // Fire held three frames launches; cooldown then counts 15 commits down
        add(0, 1'b1, 572, 1'b0, 1'b0);
        add(0, 1'b1, 572, 1'b0, 1'b0);
        add(0, 1'b1, 572, 1'b1, 1'b1);
        add(0, 1'b1, 572, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) add(0, 1'b0, 572, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) add(0, 1'b1, 572, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) add(0, 1'b0, 572, 1'b0, 1'b1);
        add(0, 1'b0, 572, 1'b0, 1'b0);
        add(0, 1'b1, 572, 1'b0, 1'b0);
        add(0, 1'b1, 572, 1'b0, 1'b0);
        add(0, 1'b1, 572, 1'b1, 1'b1);

        repeat (3) @(negedge clk_pix);
        check("rst_ship_x", 32'(ship_x), 32'd286);
        check("rst_ship_y", 32'(ship_y), 32'd300);
        check("rst_shot_req", 32'(shot_req), 32'd0);
        check("rst_shot_x", 32'(shot_x), 32'd0);
        check("rst_shot_y", 32'(shot_y), 32'd0);
        check("rst_cooldown", 32'(cooldown_active), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_pix);
        enable = 1'b1;
        @(negedge clk_pix);

        prev = 286;
        for (int i = 0; i < vecs.size(); i++) begin
            run_frame(vecs[i], i, prev);
            prev = vecs[i].exp_x;
        end

        // Mid-run reset clears the shot registers and the held position
        @(negedge clk_pix);
        rst_n = 1'b0;
        #1;
        check("rst2_ship_x", 32'(ship_x), 32'd286);
        check("rst2_shot_x", 32'(shot_x), 32'd0);
        check("rst2_cooldown", 32'(cooldown_active), 32'd0);
        @(negedge clk_pix);
        rst_n = 1'b1;
        @(negedge clk_pix);

        // Tilt strobe coincident with frame is deferred one frame
        @(negedge clk_pix);
        tilt       = 10'sd300;
        tilt_valid = 1'b1;
        frame      = 1'b1;
        @(negedge clk_pix);
        tilt_valid = 1'b0;
        frame      = 1'b0;
        repeat (4) @(negedge clk_pix);
        check("coinc_no_move", 32'(ship_x), 32'd286);
        pulse_frame(1);
        check("coinc_next_frame", 32'(ship_x), 32'd294);
        pulse_frame(3);
        check("frame_in_calc_ignored", 32'(ship_x), 32'd302);

        // Reset while in CALC aborts the pending commit
        @(negedge clk_pix);
        tilt       = 10'sd511;
        tilt_valid = 1'b1;
        @(negedge clk_pix);
        tilt_valid = 1'b0;
        frame      = 1'b1;
        @(negedge clk_pix);
        frame = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_calc_ship_x", 32'(ship_x), 32'd286);
        @(negedge clk_pix);
        rst_n = 1'b1;
        repeat (6) @(negedge clk_pix);
        check("rst_calc_no_commit", 32'(ship_x), 32'd286);
        pulse_frame(1);
        check("rst_calc_tilt_cleared", 32'(ship_x), 32'd286);
        add(511, 1'b0, 294, 1'b0, 1'b0);
        run_frame(vecs[vecs.size() - 1], vecs.size() - 1, 286);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
